// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// PwmCapture (module pwm_capture)
//
// Measures an incoming PWM waveform and reports its period, high time and a
// 10-bit duty value on the same 0..1023 scale as the motor PWM generator.
// This is the receive-side counterpart of that generator.
//
// Ports:
//   clk        system clock (100 MHz)
//   rst        synchronous, active-low reset
//   pwm_in     asynchronous PWM input
//   period     last measured period, in clk cycles
//   high_time  last measured high time, in clk cycles
//   duty       floor(high_time*1024/period), saturated to 1023
//   valid      one-cycle pulse when period/high_time/duty update
//   active     high while edges keep arriving within TIMEOUT cycles
//   overrun    one-cycle pulse when a completed period is dropped because
//              the divider was still busy
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [9:0]       duty,
    output logic             valid,
    output logic             active,
    output logic             overrun
);

    localparam int              TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      DIV_STEPS = 4'd10;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic pwm_meta;
    logic pwm_sync;
    logic pwm_prev;
    logic rise;
    logic fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cap;
    logic [TO_W-1:0]  to_cnt;

    logic start_div;
    logic drop;
    logic timeout_hit;

    logic [CNT_W:0]   div_rem;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_next;
    logic [CNT_W:0]   den_ext;
    logic [CNT_W-1:0] div_den;
    logic [CNT_W-1:0] div_hi;
    logic [8:0]       div_q;
    logic [9:0]       q_next;
    logic             q_bit;
    logic             div_sat;
    logic [3:0]       div_cnt;
    logic             div_busy;
    logic             div_done;

    logic stuck_pend;
    logic stuck_lvl;

    // Two-flop synchronizer followed by one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_meta <= 1'b0;
            pwm_sync <= 1'b0;
            pwm_prev <= 1'b0;
        end else begin
            pwm_meta <= pwm_in;
            pwm_sync <= pwm_meta;
            pwm_prev <= pwm_sync;
        end
    end

    assign rise = pwm_sync & ~pwm_prev;
    assign fall = ~pwm_sync & pwm_prev;

    // cnt restarts at 1 on every rise so that, one full period later, it
    // holds exactly the period length; the high time is grabbed at the fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            hi_cap <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (state_q == MEASURE && fall) begin
                hi_cap <= cnt;
            end
        end
    end

    // Counts consecutive edge-free cycles while measuring; holds at the
    // terminal value because the FSM leaves MEASURE on that same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state_q != MEASURE || rise || fall) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise that lands on the divider's final iteration is not a conflict:
    // the old result publishes from the combinational final step while the
    // divider reloads, so only div_busy (more than one step left) drops it.
    always_comb begin
        state_d     = state_q;
        start_div   = 1'b0;
        drop        = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (div_busy) begin
                        drop = 1'b1;
                    end else begin
                        start_div = 1'b1;
                    end
                end else if (!fall && to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One restoring-division step. The remainder stays below the divisor,
    // so one extra bit is enough to hold the shifted value.
    always_comb begin
        den_ext  = {1'b0, div_den};
        rem_sh   = div_rem << 1;
        q_bit    = (rem_sh >= den_ext);
        rem_next = q_bit ? (rem_sh - den_ext) : rem_sh;
        q_next   = {div_q, q_bit};
        div_busy = (div_cnt > 4'd1);
        div_done = (div_cnt == 4'd1);
    end

    // The divider keeps its own copies of the period and high time so that
    // later captures cannot corrupt the result that is still being computed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_rem <= '0;
            div_den <= '0;
            div_hi  <= '0;
            div_q   <= '0;
            div_sat <= 1'b0;
            div_cnt <= '0;
        end else if (start_div) begin
            div_rem <= {1'b0, hi_cap};
            div_den <= cnt;
            div_hi  <= hi_cap;
            div_q   <= '0;
            div_sat <= (hi_cap >= cnt);
            div_cnt <= DIV_STEPS;
        end else if (div_cnt != 4'd0) begin
            div_rem <= rem_next;
            div_q   <= q_next[8:0];
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // A stuck result that coincides with a running divide is parked in
    // stuck_pend and published the cycle after the divider result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            period     <= '0;
            high_time  <= '0;
            duty       <= '0;
            valid      <= 1'b0;
            active     <= 1'b0;
            overrun    <= 1'b0;
            stuck_pend <= 1'b0;
            stuck_lvl  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= drop;

            if (div_done) begin
                period    <= div_den;
                high_time <= div_hi;
                duty      <= div_sat ? 10'h3FF : q_next;
                valid     <= 1'b1;
            end else if (timeout_hit && div_cnt == 4'd0) begin
                period    <= '0;
                high_time <= '0;
                duty      <= pwm_sync ? 10'h3FF : 10'h000;
                valid     <= 1'b1;
            end else if (stuck_pend && div_cnt == 4'd0) begin
                period     <= '0;
                high_time  <= '0;
                duty       <= stuck_lvl ? 10'h3FF : 10'h000;
                valid      <= 1'b1;
                stuck_pend <= 1'b0;
            end

            if (timeout_hit && div_cnt != 4'd0) begin
                stuck_pend <= 1'b1;
                stuck_lvl  <= pwm_sync;
            end

            if (state_q == IDLE && rise) begin
                active <= 1'b1;
            end else if (timeout_hit) begin
                active <= 1'b0;
            end
        end
    end

endmodule
